// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: ALU operation codes and default width.
package mips_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_RSVD = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: optional B inversion, one shared adder, logic ops,
// overflow-corrected signed compare and zero detect.
module alu_core
    import mips_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] next_result,
    output logic             next_zero
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             overflow;
    logic             lt;

    // Operand conditioning and the shared adder; carry-in of 1 turns ~B into -B.
    always_comb begin
        bx       = alu_control[2] ? ~b : b;
        sum      = a + bx + {{(WIDTH-1){1'b0}}, alu_control[2]};
        // Overflow: operands agree in sign but the sum does not.
        overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        lt       = sum[WIDTH-1] ^ overflow;
    end

    // Result select by operation code, then zero detect on the selected value.
    always_comb begin
        next_result = '0;
        unique case (alu_control)
            ALU_AND:  next_result = a & bx;
            ALU_OR:   next_result = a | bx;
            ALU_ADD:  next_result = sum;
            ALU_RSVD: next_result = '0;
            ALU_ANDN: next_result = a & bx;
            ALU_ORN:  next_result = a | bx;
            ALU_SUB:  next_result = sum;
            ALU_SLT:  next_result = {{(WIDTH-1){1'b0}}, lt};
            default:  next_result = '0;
        endcase
        next_zero = (next_result == '0);
    end

endmodule

// File: rtl/mips_alu.sv
// MIPS ALU with registered result and zero flag; one cycle of latency and an
// asynchronous reset that forces result=0 / ZeroFlag=1.
module mips_alu
    import mips_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] result,
    output logic             ZeroFlag
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_d;
    logic             zero_q;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a           (A),
        .b           (B),
        .alu_control (ALUControl),
        .next_result (result_d),
        .next_zero   (zero_d)
    );

    // Output register: result and flag captured together so they stay coherent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result   = result_q;
    assign ZeroFlag = zero_q;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed vectors with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mips_alu;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   ALUControl;
    logic [W-1:0] result;
    logic         ZeroFlag;

    int pass_cnt;
    int total_cnt;

    logic [W-1:0] exp_r;
    logic         exp_z;
    logic         exp_v;

    mips_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .result     (result),
        .ZeroFlag   (ZeroFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: what the operation means, not how it is built.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] c);
        case (c)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return '0;
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd6: return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Model pipeline: at each edge the inputs present become next cycle's expectation.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_v = 1'b0;
        end else begin
            exp_r = model(A, B, ALUControl);
            exp_z = (exp_r == '0);
            exp_v = 1'b1;
        end
    end

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("cyc_rst_result", result, '0);
            chk("cyc_rst_zero", {31'd0, ZeroFlag}, 32'd1);
        end else if (exp_v) begin
            chk("cyc_result", result, exp_r);
            chk("cyc_zero", {31'd0, ZeroFlag}, {31'd0, exp_z});
        end
    end

    // Apply one vector, wait for the capturing edge, then check literal expectations.
    task automatic dir(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] c, input logic [W-1:0] er, input logic ez);
        A = a; B = b; ALUControl = c;
        @(posedge clk); #1;
        chk({name, "_r"}, result, er);
        chk({name, "_z"}, {31'd0, ZeroFlag}, {31'd0, ez});
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        exp_v     = 1'b0;
        reset     = 1'b1;
        A = '0; B = '0; ALUControl = 3'b000;
        #1;
        chk("reset_result", result, '0);
        chk("reset_zero", {31'd0, ZeroFlag}, 32'd1);

        // Pin the model against hand-computed values.
        chk("model_slt_min_max", model(32'h80000000, 32'h7FFFFFFF, 3'b111), 32'd1);
        chk("model_slt_max_min", model(32'h7FFFFFFF, 32'h80000000, 3'b111), 32'd0);
        chk("model_add_wrap", model(32'hFFFFFFFF, 32'd1, 3'b010), 32'd0);
        chk("model_orn", model(32'hF0F0F0F0, 32'h0F0F0F0F, 3'b101), 32'hF0F0F0F0);

        @(posedge clk); #1;
        reset = 1'b0;

        // Logic operations.
        dir("and",  32'hF0F0F0F0, 32'h0F0F0F0F, 3'b000, 32'h00000000, 1'b1);
        dir("or",   32'hF0F0F0F0, 32'h0F0F0F0F, 3'b001, 32'hFFFFFFFF, 1'b0);
        dir("andn", 32'hF0F0F0F0, 32'h0F0F0F0F, 3'b100, 32'hF0F0F0F0, 1'b0);
        dir("orn",  32'hF0F0F0F0, 32'h0F0F0F0F, 3'b101, 32'hF0F0F0F0, 1'b0);
        // Arithmetic.
        dir("add",      32'd15,       32'd10, 3'b010, 32'd25,       1'b0);
        dir("sub_eq",   32'd15,       32'd15, 3'b110, 32'd0,        1'b1);
        dir("add_wrap", 32'hFFFFFFFF, 32'd1,  3'b010, 32'd0,        1'b1);
        dir("sub_wrap", 32'd0,        32'd1,  3'b110, 32'hFFFFFFFF, 1'b0);
        // Signed compare.
        dir("slt_lt",      32'd10,       32'd11,       3'b111, 32'd1, 1'b0);
        dir("slt_gt",      32'd11,       32'd10,       3'b111, 32'd0, 1'b1);
        dir("slt_neg",     32'hFFFFFFFF, 32'd1,        3'b111, 32'd1, 1'b0);
        dir("slt_min_max", 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'd1, 1'b0);
        dir("slt_max_min", 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'd0, 1'b1);
        // Reserved code.
        dir("rsvd", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'd0, 1'b1);
        // Back-to-back op changes with fixed operands.
        dir("seq_and", 32'd15, 32'd10, 3'b000, 32'd10, 1'b0);
        dir("seq_or",  32'd15, 32'd10, 3'b001, 32'd15, 1'b0);
        dir("seq_add", 32'd15, 32'd10, 3'b010, 32'd25, 1'b0);
        dir("seq_sub", 32'd15, 32'd10, 3'b110, 32'd5,  1'b0);
        dir("seq_slt", 32'd15, 32'd10, 3'b111, 32'd0,  1'b1);

        // Asynchronous reset mid-cycle, then recovery.
        dir("pre_rst", 32'h12345678, 32'd1, 3'b010, 32'h12345679, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_result", result, '0);
        chk("async_rst_zero", {31'd0, ZeroFlag}, 32'd1);
        @(posedge clk); #1;
        chk("held_rst_result", result, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_result", result, 32'h12345679);
        chk("post_rst_zero", {31'd0, ZeroFlag}, 32'd0);

        // Randomized traffic, biased towards boundary operands.
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: rb = 32'h7FFFFFFF;
                2: rb = ra;
                3: ra = 32'hFFFFFFFF;
                default: ;
            endcase
            A = ra; B = rb; ALUControl = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
            @(posedge clk); #1;
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit integer ALU for the single-cycle MIPS datapath; executes AND/OR/ADD/SUB/SLT and the B-inverted logic variants selected by a 3-bit ALUControl code.
- Operands and control are sampled on the rising clock edge. result and ZeroFlag are registered, so the datapath sees them one cycle later.
- Sits between the register file/immediate mux (A, B) and the data-memory address / branch-compare logic (result, ZeroFlag).

Parameters:
- WIDTH, 32, operand and result width in bits. All behaviour below is stated for WIDTH=32 and must scale to any WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt or sign-extended immediate).
- ALUControl  input  3  operation select.
- result  output  WIDTH  registered operation result.
- ZeroFlag  output  1  registered; 1 exactly when the registered result is all zeros.

Behaviour:
- Reset:
  - While reset=1 (asserted asynchronously, independent of clk), result=0 and ZeroFlag=1.
  - Reset deassertion takes effect at the next rising clk edge; the first capture happens at that edge.
- Latency:
  - Exactly 1 cycle. Inputs valid before rising edge N appear on result/ZeroFlag after edge N.
  - No handshake; the block captures every cycle.
- Operation decode. ALUControl[2] selects Bx = ~B (1) or Bx = B (0):
  - 000: A & B.
  - 001: A | B.
  - 010: A + B, modulo 2^WIDTH; carry discarded.
  - 011: result 0 (reserved code); ZeroFlag=1.
  - 100: A & ~B.
  - 101: A | ~B.
  - 110: A - B, computed as A + ~B + 1, modulo 2^WIDTH.
  - 111: SLT, signed two's-complement compare. result = {WIDTH-1 zeros, (A < B signed)}.
- SLT requirements:
  - Use the sign of the subtraction corrected for overflow: lt = sum[MSB] XOR overflow.
  - Must be correct at the extremes, e.g. A=0x80000000, B=0x7FFFFFFF gives 1.
- Adder rules:
  - ADD and SUB share one WIDTH-bit adder. Carry-in = ALUControl[2] for codes 110/111.
  - No overflow trap or flag output; wrap-around is silent.
  - Example: 0xFFFFFFFF + 1 gives 0 with ZeroFlag=1.
- ZeroFlag is derived from the next-result value and registered in the same edge as result, so the two are always coherent.
- Unknown/X control is not required to be handled. Every defined code produces a defined result.
- Reset mid-operation clears both outputs immediately. The pending computation is lost, not replayed.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op encodings as named constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_RSVD=3'b011, ALU_ANDN=3'b100, ALU_ORN=3'b101, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - The WIDTH default (32).
- One natural sub-module, alu_core: purely combinational.
  - Contains the B-inversion, adder, logic ops, SLT and zero detect.
  - Produces next_result and next_zero.
- mips_alu wraps alu_core with the output register and the async reset.

Test Plan:
- Reset: assert reset with A=0x12345678, B=1, ALUControl=010 mid-cycle -> result=0x00000000 and ZeroFlag=1 immediately, without waiting for a clk edge; deassert -> after next edge result=0x12345679, ZeroFlag=0.
- Logic: A=0xF0F0F0F0, B=0x0F0F0F0F, AND -> 0x00000000/Z=1. OR -> 0xFFFFFFFF/Z=0. 100 -> 0xF0F0F0F0. 101 -> 0xF0F0F0F0.
- Arithmetic: ADD 15+10 -> 25/Z=0. SUB 15-15 -> 0/Z=1. ADD 0xFFFFFFFF+1 -> 0/Z=1. SUB 0-1 -> 0xFFFFFFFF/Z=0.
- SLT: 10<11 -> 1/Z=0. 11 vs 10 -> 0/Z=1. A=0xFFFFFFFF, B=1 -> 1. A=0x80000000, B=0x7FFFFFFF -> 1. A=0x7FFFFFFF, B=0x80000000 -> 0.
- Latency/pipelining: change ALUControl every cycle (000, 001, 010, 110, 111) with fixed A, B -> each result appears exactly one edge after its inputs, with no skipped or repeated values.
- Reserved code 011 with A=0xFFFFFFFF, B=0xFFFFFFFF -> result=0, ZeroFlag=1.
